// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
// frame_pkg : frame states and serial line levels shared by TX and RX sides
// Revision  : 1.0
// ============================================================================
package frame_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage : frame_pkg
`default_nettype wire

// File: rtl/piso_frame_tx.sv
`default_nettype none
// ============================================================================
// piso_frame_tx : framed parallel-to-serial transmitter (start, LSB-first data,
//                 optional parity, stop), back-to-back frames without gaps
// Revision      : 1.0
// ============================================================================
module piso_frame_tx
   import frame_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             so,
   output logic             busy,
   output logic             done
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

   tx_state_t        state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             par_q, par_d;
   logic             so_q, so_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept;

   assign load_ready = (state_q == IDLE) || (state_q == STOP);
   assign accept     = load_valid && load_ready;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      case (state_q)
         IDLE, STOP: begin
            if (accept) begin
               state_d = START;
               shift_d = din;
               par_d   = (PARITY_ODD != 0) ? ~^din : ^din;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            state_d = DATA;
            cnt_d   = '0;
         end
         DATA: begin
            if (cnt_q == LAST_BIT) begin
               state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               shift_d = shift_q >> 1;
            end
         end
         PARITY:  state_d = STOP;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      so_d = LINE_IDLE;
      case (state_d)
         START:   so_d = START_BIT;
         DATA:    so_d = shift_d[0];
         PARITY:  so_d = par_q;
         STOP:    so_d = STOP_BIT;
         default: so_d = LINE_IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == STOP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         so_q    <= LINE_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         so_q    <= so_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign so   = so_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule : piso_frame_tx
`default_nettype wire

// File: tb/tb_piso_frame_tx.sv
`default_nettype none
// ============================================================================
// tb_piso_frame_tx : three transmitter variants (even, odd, no parity) driven
//                    by shared stimulus, each checked against a frame queue
// Revision         : 1.0
// ============================================================================
module tb_piso_frame_tx;

   localparam int NI = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    din;
   logic          load_valid;
   logic [NI-1:0] rdy_w, so_w, busy_w, done_w;

   bit            exp_q [NI][$];
   bit            chk_en = 1'b0;
   int            n_vec  = 0;
   int            n_err  = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      piso_frame_tx #(
         .WIDTH      (8),
         .PARITY_EN  ((gi != 2) ? 1 : 0),
         .PARITY_ODD ((gi == 1) ? 1 : 0)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .din        (din),
         .load_valid (load_valid),
         .load_ready (rdy_w[gi]),
         .so         (so_w[gi]),
         .busy       (busy_w[gi]),
         .done       (done_w[gi])
      );
   end

   function automatic bit has_par(int i);
      return i != 2;
   endfunction

   function automatic bit is_odd(int i);
      return i == 1;
   endfunction

   // Whole frame as the line should show it, one entry per clock.
   task automatic push_frame(int i, logic [7:0] d);
      int ones;
      ones = $countones(d);
      exp_q[i].push_back(1'b0);
      for (int b = 0; b < 8; b++) exp_q[i].push_back(d[b]);
      if (has_par(i)) exp_q[i].push_back(is_odd(i) ? (ones % 2 == 0) : (ones % 2 == 1));
      exp_q[i].push_back(1'b1);
   endtask

   // Reference: a variant takes a word whenever nothing remains to be sent
   // after the current cycle; reset discards anything pending.
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (rst) exp_q[i].delete();
         else if (load_valid && exp_q[i].size() == 0) push_frame(i, din);
      end
   end

   task automatic chk(string nm, int i, logic act, logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d] at %0t: got %b expected %b", nm, i, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            bit e_so, e_busy, e_done;
            if (exp_q[i].size() > 0) begin
               e_so   = exp_q[i].pop_front();
               e_busy = 1'b1;
               e_done = (exp_q[i].size() == 0);
            end else begin
               e_so   = 1'b1;
               e_busy = 1'b0;
               e_done = 1'b0;
            end
            chk("so", i, so_w[i], e_so);
            chk("busy", i, busy_w[i], e_busy);
            chk("done", i, done_w[i], e_done);
            chk("load_ready", i, rdy_w[i], exp_q[i].size() == 0);
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send1(logic [7:0] d, int idle);
      din        = d;
      load_valid = 1'b1;
      cyc(1);
      load_valid = 1'b0;
      cyc(idle);
   endtask

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      din        = 8'h00;
      cyc(2);
      rst    = 1'b0;
      chk_en = 1'b1;
      cyc(1);

      send1(8'hA5, 14);
      send1(8'h07, 14);

      // back-to-back: valid held across the stop cycle of the first frame
      din        = 8'hA5;
      load_valid = 1'b1;
      cyc(1);
      din = 8'h3C;
      cyc(11);
      load_valid = 1'b0;
      cyc(25);

      // reset while data bit 3 is on the line
      send1(8'hFF, 4);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      send1(8'h01, 14);

      send1(8'h80, 30);

      for (int n = 0; n < 2000; n++) begin
         din        = 8'($urandom);
         load_valid = ($urandom_range(0, 3) != 0);
         rst        = ($urandom_range(0, 59) == 0);
         cyc(1);
      end
      rst        = 1'b0;
      load_valid = 1'b0;
      cyc(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_piso_frame_tx
`default_nettype wire
